fifo_pop_upsizer: RTL and testbench
===================================

// Module: fifo_pop_upsizer
// PURPOSE
//  Downstream consumer of the flop-based FIFO pop interface. Collects Ratio narrow
//  beats of Width bits and emits one Width*Ratio-bit word over a ready/valid port.
//  Used where a narrow FIFO feeds a wide datapath. Full throughput: one narrow beat
//  accepted per cycle while the output keeps draining.
// PARAMETERS
//  Width  8  narrow beat width in bits (>=1)
//  Ratio  4  narrow beats per wide word (>=2)
// PORTS
//  clk         in   1             clock, rising edge
//  rst         in   1             asynchronous reset, active-high
//  push_valid  in   1             narrow beat valid (driven by FIFO pop_valid)
//  push_ready  out  1             narrow beat ready (drives FIFO pop_ready)
//  push_data   in   Width         narrow beat data
//  push_last   in   1             close word early (only with FIFO_POP_UPSIZER_LAST_EN)
//  pop_valid   out  1             wide word valid
//  pop_ready   in   1             wide word ready
//  pop_data    out  Width*Ratio   wide word; beat k occupies bits [k*Width +: Width]
//  pop_keep    out  Ratio         lane-filled mask (only with FIFO_POP_UPSIZER_LAST_EN)
//  fill        out  $clog2(Ratio) lanes held in the accumulator (not yet emitted)
// BEHAVIOUR
//  - Reset (async assert, sync deassert handled upstream):
//    pop_valid=0, pop_data=0, pop_keep=0, fill=0, accumulator=0.
//  - Push beat: push_valid & push_ready.
//    - A beat with fill<Ratio-1 is written to lane fill and fill is incremented.
//    - The final beat (fill==Ratio-1) forms a word from accumulator plus push_data.
//      The word is loaded into the output register and fill returns to 0.
//  - push_ready = (fill != Ratio-1) | ~pop_valid | pop_ready.
//    Non-final lanes are always accepted, so the accumulator is independent of the
//    output register. push_ready must not depend on push_valid.
//  - Latency: pop_valid rises the cycle after the final push beat.
//    Pop beat and final push beat in the same cycle -> output reloads, no bubble.
//  - Once pop_valid=1, pop_data is held stable until pop_ready. The output does
//    not retract.
//  - Lane 0 is the first-received beat (little-endian packing).
//    Accumulator lanes not yet written read as 0.
//  - fill is a pure counter: 0..Ratio-1, wraps to 0 on the word-closing beat.
//  - A reset mid-word discards the partial accumulator and any unpopped output word.
//    There is no recovery of lost beats.
//  - Protocol assertions (sim only):
//    push_valid/push_data stable while push_valid & ~push_ready;
//    pop_ready may toggle freely; no X on push_valid/pop_ready out of reset.
// CONFIGURATION
//  FIFO_POP_UPSIZER_LAST_EN
//  - Defined:
//    - push_last and pop_keep exist.
//    - A push beat with push_last=1 closes the word regardless of fill.
//    - pop_keep has bits [0..fill] set; unfilled lanes of pop_data are 0.
//    - The push_ready rule for the closing beat applies to any beat with push_last=1.
//    - A word closed at full Ratio has pop_keep all-ones.
//  - Undefined:
//    - Neither port exists.
//    - Every word is exactly Ratio beats and closes only at fill==Ratio-1.
// STRUCTURE
//  - fifo_pop_upsizer_pkg:
//    - localparam function for FillWidth = max(1,$clog2(Ratio)).
//    - typedef for the lane-index type.
//    - Assertion message strings.
//  - One sub-module, fifo_pop_upsizer_out_reg.
//    - A single-entry ready/valid output register with hold-on-stall and async reset.
//    - Reusable elsewhere as a pipeline stage.
//  - The accumulator and fill counter live in the top module.
// TESTING (Width=8, Ratio=4 unless noted)
//  1 Stream beats 0x11,0x22,0x33,0x44 with pop_ready=1.
//    -> pop_valid=1 the cycle after 0x44, pop_data=0x44332211; fill goes 0,1,2,3,0.
//  2 pop_ready=0, stream beats 0x11..0x88.
//    -> word 0x44332211 held stable; push_ready=0 while 0x88 is offered.
//    Raise pop_ready -> 0x88 accepted; next word 0x88776655 follows.
//  3 Continuous push and pop_ready=1 for 32 beats.
//    -> 8 words back-to-back, no idle cycles on either port.
//  4 Push 0xA1,0xA2, then assert rst asynchronously mid-cycle.
//    -> pop_valid=0 and fill=0 immediately. After release, 0x01..0x04 -> 0x04030201.
//  5 LAST_EN: push 0xAA, then 0xBB with push_last=1.
//    -> pop_data=0x0000BBAA, pop_keep=4'b0011, fill=0.
//    A single-beat last gives pop_keep=4'b0001.
//  6 Ratio=2, Width=16, random valid/ready (10k beats).
//    -> scoreboard matches packed words exactly; no assertion fires.

Source files
------------

// File: rtl/fifo_pop_upsizer_pkg.sv
// rtl/fifo_pop_upsizer_pkg.sv - shared sizing helper, lane index type and assertion messages
package fifo_pop_upsizer_pkg;

  function automatic int fill_width(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  typedef int unsigned lane_idx_t;

  localparam string MsgPushUnstable = "push_valid/push_data changed while stalled";
  localparam string MsgUnknownCtrl  = "X/Z on push_valid or pop_ready";

endpackage

// File: rtl/fifo_pop_upsizer_out_reg.sv
// rtl/fifo_pop_upsizer_out_reg.sv - single-entry ready/valid register, holds data on stall
module fifo_pop_upsizer_out_reg #(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [DataWidth-1:0] s_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [DataWidth-1:0] m_tdata
);

  // A pop in the same cycle frees the slot, so reloads happen without a bubble.
  assign s_tready = ~m_tvalid | m_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
    end else if (s_tvalid && s_tready) begin
      m_tvalid <= 1'b1;
      m_tdata  <= s_tdata;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_pop_upsizer.sv
// rtl/fifo_pop_upsizer.sv - packs Ratio narrow FIFO beats into one wide word (option: FIFO_POP_UPSIZER_LAST_EN)
module fifo_pop_upsizer
  import fifo_pop_upsizer_pkg::*;
#(
  parameter int Width = 8,
  parameter int Ratio = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [Width-1:0]         push_data,
`ifdef FIFO_POP_UPSIZER_LAST_EN
  input  logic                     push_last,
  output logic [Ratio-1:0]         pop_keep,
`endif
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [Width*Ratio-1:0]   pop_data,
  output logic [$clog2(Ratio)-1:0] fill
);

  localparam int FillWidth = fill_width(Ratio);
  localparam int WordWidth = Width * Ratio;

  logic [FillWidth-1:0] fill_q;
  logic [WordWidth-1:0] acc_q;
  logic [WordWidth-1:0] word;
  logic                 close;
  logic                 push_fire;
  logic                 out_tready;

  always_comb begin
    word = acc_q;
    for (lane_idx_t k = 0; k < Ratio; k++) begin
      if (FillWidth'(k) == fill_q) word[k*Width +: Width] = push_data;
    end
  end

`ifdef FIFO_POP_UPSIZER_LAST_EN
  logic [Ratio-1:0] keep;

  always_comb begin
    keep = '0;
    for (lane_idx_t k = 0; k < Ratio; k++) begin
      if (FillWidth'(k) <= fill_q) keep[k] = 1'b1;
    end
  end

  assign close = (fill_q == FillWidth'(Ratio - 1)) | push_last;
`else
  assign close = (fill_q == FillWidth'(Ratio - 1));
`endif

  // Only a word-closing beat needs room in the output register.
  assign push_ready = ~close | out_tready;
  assign push_fire  = push_valid & push_ready;
  assign fill       = fill_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= '0;
      acc_q  <= '0;
    end else if (push_fire) begin
      if (close) begin
        fill_q <= '0;
        acc_q  <= '0;
      end else begin
        fill_q <= fill_q + 1'b1;
        acc_q  <= word;
      end
    end
  end

`ifdef FIFO_POP_UPSIZER_LAST_EN
  fifo_pop_upsizer_out_reg #(.DataWidth(WordWidth + Ratio)) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (push_fire & close),
    .s_tready (out_tready),
    .s_tdata  ({keep, word}),
    .m_tvalid (pop_valid),
    .m_tready (pop_ready),
    .m_tdata  ({pop_keep, pop_data})
  );
`else
  fifo_pop_upsizer_out_reg #(.DataWidth(WordWidth)) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (push_fire & close),
    .s_tready (out_tready),
    .s_tdata  (word),
    .m_tvalid (pop_valid),
    .m_tready (pop_ready),
    .m_tdata  (pop_data)
  );
`endif

  a_push_stable: assert property (@(posedge clk) disable iff (rst)
    (push_valid && !push_ready) |=> (push_valid && $stable(push_data)))
    else $error("%s", MsgPushUnstable);

  a_ctrl_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({push_valid, pop_ready}))
    else $error("%s", MsgUnknownCtrl);

endmodule

// File: tb/tb_fifo_pop_upsizer.sv
// tb/tb_fifo_pop_upsizer.sv - scoreboard bench for fifo_pop_upsizer (option: FIFO_POP_UPSIZER_LAST_EN)
module tb_fifo_pop_upsizer;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int W2 = 16;
  localparam int R2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           push_valid = 1'b0;
  logic           push_ready;
  logic [W-1:0]   push_data  = '0;
  logic           pop_valid;
  logic           pop_ready  = 1'b0;
  logic [W*R-1:0] pop_data;
  logic [1:0]     fill;

  logic            p2_valid = 1'b0;
  logic            p2_ready;
  logic [W2-1:0]   p2_data  = '0;
  logic            q2_valid;
  logic            q2_ready = 1'b0;
  logic [W2*R2-1:0] q2_data;
  logic [0:0]      fill2;

`ifdef FIFO_POP_UPSIZER_LAST_EN
  logic          push_last = 1'b0;
  logic [R-1:0]  pop_keep;
  logic          p2_last   = 1'b0;
  logic [R2-1:0] q2_keep;
`endif

  fifo_pop_upsizer #(.Width(W), .Ratio(R)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
`ifdef FIFO_POP_UPSIZER_LAST_EN
    .push_last(push_last), .pop_keep(pop_keep),
`endif
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data), .fill(fill)
  );

  fifo_pop_upsizer #(.Width(W2), .Ratio(R2)) dut2 (
    .clk(clk), .rst(rst),
    .push_valid(p2_valid), .push_ready(p2_ready), .push_data(p2_data),
`ifdef FIFO_POP_UPSIZER_LAST_EN
    .push_last(p2_last), .pop_keep(q2_keep),
`endif
    .pop_valid(q2_valid), .pop_ready(q2_ready), .pop_data(q2_data), .fill(fill2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard for dut: model packs accepted beats, compares at every pop.
  logic [W*R-1:0] exp_q[$];
  logic [R-1:0]   exp_k[$];
  logic [W*R-1:0] acc_m  = '0;
  int             lane_m = 0;
  int             n_pops = 0;
  logic           tb_last;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      exp_k.delete();
      acc_m  = '0;
      lane_m = 0;
    end else begin
      if (pop_valid && pop_ready) begin
        n_pops++;
        check_eq("sb_has_word", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          check_eq("sb_pop_data", 64'(pop_data), 64'(exp_q.pop_front()));
`ifdef FIFO_POP_UPSIZER_LAST_EN
          check_eq("sb_pop_keep", 64'(pop_keep), 64'(exp_k.pop_front()));
`endif
        end
      end
`ifdef FIFO_POP_UPSIZER_LAST_EN
      tb_last = push_last;
`else
      tb_last = 1'b0;
`endif
      if (push_valid && push_ready) begin
        acc_m[lane_m*W +: W] = push_data;
        lane_m++;
        if (lane_m == R || tb_last) begin
          exp_q.push_back(acc_m);
          exp_k.push_back(R'((1 << lane_m) - 1));
          acc_m  = '0;
          lane_m = 0;
        end
      end
    end
  end

  logic [W2*R2-1:0] exp2_q[$];
  logic [W2*R2-1:0] acc2_m  = '0;
  int               lane2_m = 0;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      exp2_q.delete();
      acc2_m  = '0;
      lane2_m = 0;
    end else begin
      if (q2_valid && q2_ready) begin
        check_eq("sb2_has_word", 64'(exp2_q.size() != 0), 64'd1);
        if (exp2_q.size() != 0) check_eq("sb2_pop_data", 64'(q2_data), 64'(exp2_q.pop_front()));
      end
      if (p2_valid && p2_ready) begin
        acc2_m[lane2_m*W2 +: W2] = p2_data;
        lane2_m++;
        if (lane2_m == R2) begin
          exp2_q.push_back(acc2_m);
          acc2_m  = '0;
          lane2_m = 0;
        end
      end
    end
  end

  task automatic push_beat(input logic [W-1:0] d, input logic last);
    int n = 0;
    push_valid = 1'b1;
    push_data  = d;
`ifdef FIFO_POP_UPSIZER_LAST_EN
    push_last  = last;
`else
    if (last) $display("push_last ignored in this build");
`endif
    @(negedge clk);
    while (!push_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("push_accept_bound", 64'(n < 200), 64'd1);
    @(posedge clk);
    #1;
    push_valid = 1'b0;
`ifdef FIFO_POP_UPSIZER_LAST_EN
    push_last  = 1'b0;
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] b1[4];
    int n0;
    int sent;
    int cyc;
    logic acc;
    b1[0] = 8'h11; b1[1] = 8'h22; b1[2] = 8'h33; b1[3] = 8'h44;

    #12;
    check_eq("rst_pop_valid", 64'(pop_valid), 64'd0);
    check_eq("rst_pop_data", 64'(pop_data), 64'd0);
    check_eq("rst_fill", 64'(fill), 64'd0);
    check_eq("rst_q2_valid", 64'(q2_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: one word, free-flowing output
    pop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1;
      push_data  = b1[i];
      @(negedge clk);
      check_eq("t1_fill", 64'(fill), 64'(i));
      check_eq("t1_ready", 64'(push_ready), 64'd1);
      check_eq("t1_no_early_valid", 64'(pop_valid), 64'd0);
      @(posedge clk); #1;
    end
    push_valid = 1'b0;
    @(negedge clk);
    check_eq("t1_valid_latency", 64'(pop_valid), 64'd1);
    check_eq("t1_pop_data", 64'(pop_data), 64'h44332211);
    check_eq("t1_fill_wrap", 64'(fill), 64'd0);
    @(posedge clk); #1;

    // 2: stalled output holds word and back-pressures only the closing beat
    pop_ready = 1'b0;
    for (int i = 1; i <= 7; i++) push_beat(8'(i * 8'h11), 1'b0);
    push_valid = 1'b1;
    push_data  = 8'h88;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t2_stall_ready", 64'(push_ready), 64'd0);
      check_eq("t2_hold_valid", 64'(pop_valid), 64'd1);
      check_eq("t2_hold_data", 64'(pop_data), 64'h44332211);
      @(posedge clk); #1;
    end
    pop_ready = 1'b1;
    @(negedge clk);
    check_eq("t2_release_ready", 64'(push_ready), 64'd1);
    @(posedge clk); #1;
    push_valid = 1'b0;
    @(negedge clk);
    check_eq("t2_reload_valid", 64'(pop_valid), 64'd1);
    check_eq("t2_reload_data", 64'(pop_data), 64'h88776655);
    @(posedge clk); #1;

    // 3: continuous streaming, push side must never stall
    n0 = n_pops;
    for (int i = 0; i < 32; i++) begin
      push_valid = 1'b1;
      push_data  = 8'($urandom);
      @(negedge clk);
      check_eq("t3_no_stall", 64'(push_ready), 64'd1);
      @(posedge clk); #1;
    end
    push_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    check_eq("t3_word_count", 64'(n_pops - n0), 64'd8);
    check_eq("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // 4: asynchronous reset mid-word with a held output word
    pop_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_beat(b1[i], 1'b0);
    push_beat(8'hA1, 1'b0);
    push_beat(8'hA2, 1'b0);
    check_eq("t4_pre_fill", 64'(fill), 64'd2);
    #2 rst = 1'b1;
    #1;
    check_eq("t4_rst_valid", 64'(pop_valid), 64'd0);
    check_eq("t4_rst_fill", 64'(fill), 64'd0);
    check_eq("t4_rst_data", 64'(pop_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pop_ready = 1'b1;
    for (int i = 1; i <= 4; i++) push_beat(8'(i), 1'b0);
    @(negedge clk);
    check_eq("t4_post_data", 64'(pop_data), 64'h04030201);
    check_eq("t4_post_valid", 64'(pop_valid), 64'd1);
    @(posedge clk); #1;

`ifdef FIFO_POP_UPSIZER_LAST_EN
    // 5: early close via push_last
    push_beat(8'hAA, 1'b0);
    push_beat(8'hBB, 1'b1);
    @(negedge clk);
    check_eq("t5_data", 64'(pop_data), 64'h0000BBAA);
    check_eq("t5_keep", 64'(pop_keep), 64'b0011);
    check_eq("t5_fill", 64'(fill), 64'd0);
    @(posedge clk); #1;
    push_beat(8'hCC, 1'b1);
    @(negedge clk);
    check_eq("t5_single_data", 64'(pop_data), 64'h000000CC);
    check_eq("t5_single_keep", 64'(pop_keep), 64'b0001);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push_beat(b1[i], 1'b0);
    @(negedge clk);
    check_eq("t5_full_keep", 64'(pop_keep), 64'b1111);
    @(posedge clk); #1;
`endif

    // 6: Ratio=2, Width=16 instance under random valid/ready
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      if (!p2_valid && $urandom_range(3) != 0) begin
        p2_valid = 1'b1;
        p2_data  = 16'($urandom);
      end
      q2_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      acc = p2_valid && p2_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        p2_valid = 1'b0;
      end
    end
    check_eq("t6_all_sent", 64'(sent), 64'd10000);
    p2_valid = 1'b0;
    q2_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("t6_sb_empty", 64'(exp2_q.size()), 64'd0);
    check_eq("t6_fill2", 64'(fill2), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
